// File: rtl/mc_control_fsm.sv
// RV32I multi-cycle main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mc_control_fsm #(
    parameter logic MEM_HANDSHAKE = 1'b1,
    parameter logic EXT_OPS       = 1'b1,
    parameter logic TRAP_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic       instr_done
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JALR1, S_JALR2,
        S_LUI, S_AUIPC, S_TRAP
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_ready;
    logic   w_pc_update;
    logic   w_branch;

    assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        imm_src = 3'b000;
        if (op == OP_SW)                             imm_src = 3'b001;
        else if (op == OP_BEQ)                       imm_src = 3'b010;
        else if (op == OP_JAL)                       imm_src = 3'b011;
        else if (EXT_OPS && (op == OP_LUI || op == OP_AUIPC)) imm_src = 3'b100;
    end

    always_comb begin
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                ir_write    = w_ready;
                w_pc_update = w_ready;
                if (w_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op == OP_LW || op == OP_SW)    w_next = S_MEMADR;
                else if (op == OP_R)               w_next = S_EXECR;
                else if (op == OP_I)               w_next = S_EXECI;
                else if (op == OP_BEQ)             w_next = S_BEQ;
                else if (op == OP_JAL)             w_next = S_JAL;
                else if (EXT_OPS && op == OP_JALR)  w_next = S_JALR1;
                else if (EXT_OPS && op == OP_LUI)   w_next = S_LUI;
                else if (EXT_OPS && op == OP_AUIPC) w_next = S_AUIPC;
                else w_next = TRAP_EN ? S_TRAP : S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (w_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (w_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            // JAL and JALR2 both load the PC and leave old_pc+4 in alu_out
            S_JAL, S_JALR2: begin
                w_pc_update = 1'b1;
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_next      = S_ALUWB;
            end
            S_JALR1: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_JALR2;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign pc_write   = w_pc_update | (w_branch & zero);
    assign instr_done = (w_next == S_FETCH) && (r_state != S_FETCH);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: three parameter variants share stimulus,
// expected outputs are queued by the driver and checked by a negedge monitor.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [2:0] pcw, adr, mw, irw, rw, ill, dn;
    logic [1:0] rs [3];
    logic [1:0] sa [3];
    logic [1:0] sb [3];
    logic [1:0] ao [3];
    logic [2:0] im [3];
    logic [17:0] got [3];

    always #5 clk = ~clk;

    // dut 0: defaults, dut 1: EXT_OPS=0, dut 2: TRAP_EN=0
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control_fsm #(
            .MEM_HANDSHAKE(1'b1),
            .EXT_OPS(g != 1),
            .TRAP_EN(g != 2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
            .mem_ready(mem_ready),
            .pc_write(pcw[g]), .adr_src(adr[g]), .mem_write(mw[g]),
            .ir_write(irw[g]), .reg_write(rw[g]), .result_src(rs[g]),
            .alu_src_a(sa[g]), .alu_src_b(sb[g]), .alu_op(ao[g]),
            .imm_src(im[g]), .illegal(ill[g]), .instr_done(dn[g])
        );
        assign got[g] = {pcw[g], adr[g], mw[g], irw[g], rw[g], rs[g],
                         sa[g], sb[g], ao[g], im[g], ill[g], dn[g]};
    end

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
    localparam int ER = 6, EI = 7, AWB = 8, BQ = 9, JL = 10, JR1 = 11;
    localparam int JR2 = 12, LU = 13, AU = 14, TR = 15;

    typedef struct {
        int          sel;
        string       nm;
        logic [17:0] exp;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    logic [2:0] cur_imm;

    // bits: pc adr mw ir rw rs[2] a[2] b[2] op[2] imm[3] ill done
    function automatic logic [17:0] ev(input int st, input logic [2:0] imm,
                                       input logic z, input logic mr,
                                       input logic done);
        logic pc, ad, w, ir, r, il;
        logic [1:0] s, a, b, o;
        {pc, ad, w, ir, r, il} = '0;
        {s, a, b, o} = '0;
        case (st)
            F:   begin pc = mr; ir = mr; s = 2'b10; b = 2'b10; end
            D:   begin a = 2'b01; b = 2'b01; end
            MA:  begin a = 2'b10; b = 2'b01; end
            MR:  begin ad = 1'b1; end
            MWB: begin s = 2'b01; r = 1'b1; end
            MW:  begin ad = 1'b1; w = 1'b1; end
            ER:  begin a = 2'b10; o = 2'b10; end
            EI:  begin a = 2'b10; b = 2'b01; o = 2'b10; end
            AWB: begin r = 1'b1; end
            BQ:  begin a = 2'b10; o = 2'b01; pc = z; end
            JL:  begin pc = 1'b1; a = 2'b01; b = 2'b10; end
            JR1: begin a = 2'b10; b = 2'b01; end
            JR2: begin pc = 1'b1; a = 2'b01; b = 2'b10; end
            LU:  begin a = 2'b11; b = 2'b01; end
            AU:  begin a = 2'b01; b = 2'b01; end
            TR:  begin il = 1'b1; end
            default: ;
        endcase
        return {pc, ad, w, ir, r, s, a, b, o, imm, il, done};
    endfunction

    task automatic push(input int sel, input string nm, input logic [17:0] e);
        exp_t x;
        x.sel = sel;
        x.nm  = nm;
        x.exp = e;
        q.push_back(x);
    endtask

    // one cycle of dut 0 in state st; caller is at posedge+1
    task automatic step(input string nm, input int st, input logic mr,
                        input logic done);
        mem_ready = mr;
        push(0, nm, ev(st, cur_imm, zero, mr, done));
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] imm,
                         input logic z);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        op = o;
        zero = z;
        cur_imm = imm;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            tests++;
            if (got[x.sel] !== x.exp) begin
                fails++;
                $display("FAIL %s dut%0d: got %b expected %b",
                         x.nm, x.sel, got[x.sel], x.exp);
            end
        end
    end

    initial begin
        cur_imm = 3'b000;
        op = 7'b0000011;
        #2;
        push(0, "reset", ev(F, 3'b000, 1'b0, 1'b0, 1'b0));
        push(2, "reset_d2", ev(F, 3'b000, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;

        start(7'b0000011, 3'b000, 1'b0);
        step("lw_f", F, 1'b1, 1'b0);
        step("lw_d", D, 1'b1, 1'b0);
        step("lw_ma", MA, 1'b1, 1'b0);
        step("lw_mr", MR, 1'b1, 1'b0);
        step("lw_wb", MWB, 1'b1, 1'b1);
        step("lw_ret", F, 1'b1, 1'b0);

        start(7'b0000011, 3'b000, 1'b0);
        step("lwws_f0", F, 1'b0, 1'b0);
        step("lwws_f1", F, 1'b0, 1'b0);
        step("lwws_f2", F, 1'b1, 1'b0);
        step("lwws_d", D, 1'b1, 1'b0);
        step("lwws_ma", MA, 1'b0, 1'b0);
        step("lwws_mr0", MR, 1'b0, 1'b0);
        step("lwws_mr1", MR, 1'b1, 1'b0);
        step("lwws_wb", MWB, 1'b0, 1'b1);

        start(7'b0100011, 3'b001, 1'b0);
        step("sw_f", F, 1'b1, 1'b0);
        step("sw_d", D, 1'b1, 1'b0);
        step("sw_ma", MA, 1'b1, 1'b0);
        step("sw_w0", MW, 1'b0, 1'b0);
        step("sw_w1", MW, 1'b0, 1'b0);
        step("sw_w2", MW, 1'b0, 1'b0);
        step("sw_w3", MW, 1'b1, 1'b1);
        step("sw_ret", F, 1'b1, 1'b0);

        start(7'b0100011, 3'b001, 1'b0);
        step("swab_f", F, 1'b1, 1'b0);
        step("swab_d", D, 1'b1, 1'b0);
        step("swab_ma", MA, 1'b0, 1'b0);
        step("swab_w", MW, 1'b0, 1'b0);
        rst_n = 1'b0;
        push(0, "sw_abort", ev(F, 3'b001, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;

        start(7'b1100011, 3'b010, 1'b1);
        step("beq1_f", F, 1'b1, 1'b0);
        step("beq1_d", D, 1'b1, 1'b0);
        step("beq1_b", BQ, 1'b1, 1'b1);
        start(7'b1100011, 3'b010, 1'b0);
        step("beq0_f", F, 1'b1, 1'b0);
        step("beq0_d", D, 1'b1, 1'b0);
        step("beq0_b", BQ, 1'b1, 1'b1);

        start(7'b1100111, 3'b000, 1'b0);
        step("jalr_f", F, 1'b1, 1'b0);
        push(1, "jalrx_d", ev(D, 3'b000, 1'b0, 1'b1, 1'b0));
        step("jalr_d", D, 1'b1, 1'b0);
        push(1, "jalrx_trap", ev(TR, 3'b000, 1'b0, 1'b1, 1'b0));
        step("jalr_1", JR1, 1'b1, 1'b0);
        push(1, "jalrx_trap2", ev(TR, 3'b000, 1'b0, 1'b1, 1'b0));
        step("jalr_2", JR2, 1'b1, 1'b0);
        step("jalr_wb", AWB, 1'b1, 1'b1);

        start(7'b1111111, 3'b000, 1'b0);
        push(2, "nop_f", ev(F, 3'b000, 1'b0, 1'b1, 1'b0));
        step("unk_f", F, 1'b1, 1'b0);
        push(2, "nop_d", ev(D, 3'b000, 1'b0, 1'b1, 1'b1));
        step("unk_d", D, 1'b1, 1'b0);
        push(2, "nop_ret", ev(F, 3'b000, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 20; i++) step("unk_trap", TR, 1'b1, 1'b0);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        push(0, "trap_async_rst", ev(F, 3'b000, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;

        start(7'b0110111, 3'b100, 1'b0);
        step("lui_f", F, 1'b1, 1'b0);
        step("lui_d", D, 1'b1, 1'b0);
        step("lui_x", LU, 1'b1, 1'b0);
        step("lui_wb", AWB, 1'b1, 1'b1);

        start(7'b0010111, 3'b100, 1'b0);
        step("auipc_f", F, 1'b1, 1'b0);
        step("auipc_d", D, 1'b1, 1'b0);
        step("auipc_x", AU, 1'b1, 1'b0);
        step("auipc_wb", AWB, 1'b1, 1'b1);

        start(7'b1101111, 3'b011, 1'b0);
        step("jal_f", F, 1'b1, 1'b0);
        step("jal_d", D, 1'b1, 1'b0);
        step("jal_x", JL, 1'b1, 1'b0);
        step("jal_wb", AWB, 1'b1, 1'b1);

        start(7'b0110011, 3'b000, 1'b0);
        step("r_f", F, 1'b1, 1'b0);
        step("r_d", D, 1'b1, 1'b0);
        step("r_x", ER, 1'b1, 1'b0);
        step("r_wb", AWB, 1'b1, 1'b1);

        start(7'b0010011, 3'b000, 1'b0);
        step("i_f", F, 1'b1, 1'b0);
        step("i_d", D, 1'b1, 1'b0);
        step("i_x", EI, 1'b1, 1'b0);
        step("i_wb", AWB, 1'b1, 1'b1);

        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control unit for the RV32I core. It is the successor to the combinational immediate-source decoder: it sequences every instruction through fetch, decode, execute, memory and writeback states and drives all datapath enables and mux selects, including `imm_src`. It extends the supported opcodes with jalr, lui and auipc, adds a memory ready handshake, and adds an illegal-opcode trap. It sits between the instruction register's opcode field and the multi-cycle datapath.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 means memory states wait on `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.
- `EXT_OPS`, default 1: 1 means jalr, lui and auipc are decoded; 0 means they are treated as unknown opcodes.
- `TRAP_EN`, default 1: 1 means an unknown opcode enters TRAP; 0 means an unknown opcode retires as a nop.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction register bits [6:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write` out 1: PC load enable, equal to `pc_update | (branch & zero)`.
- `adr_src` out 1: memory address select; 0 = PC, 1 = result.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register and old-PC load enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux select; 00 = alu_out, 01 = data, 10 = alu_result.
- `alu_src_a` out 2: ALU operand A select; 00 = PC, 01 = old_pc, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: ALU operand B select; 00 = rs2, 01 = imm, 10 = const 4.
- `alu_op` out 2: ALU operation; 00 = add, 01 = sub, 10 = decode from funct fields.
- `imm_src` out 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal` out 1: high while in TRAP.
- `instr_done` out 1: one-cycle pulse on each retire (any transition into FETCH).

## Operation
- Moore FSM with a registered state. Outputs are combinational from the state, plus the `mem_ready` gating and the `imm_src` decode described below.
- Any output not listed for a state is 0.
- `imm_src` is decoded from `op` in every state: lw, I-type and jalr → 000; sw → 001; beq → 010; jal → 011; lui and auipc → 100; anything else → 000.
- FETCH:
  - adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when it is 1.
- DECODE: src_a=01, src_b=01, alu_op=00, so alu_out holds the branch/jump target. Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 1100111 → JALR1
  - 0110111 → LUI
  - 0010111 → AUIPC
  - otherwise → TRAP if `TRAP_EN`, else FETCH.
  - When `EXT_OPS`=0, the jalr, lui and auipc opcodes follow the "otherwise" path.
- MEMADR: src_a=10, src_b=01, alu_op=00. Goes to MEMREAD if op=lw, else to MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 for every cycle spent in the state. Holds until `mem_ready`, then FETCH.
- EXECUTER: src_a=10, src_b=00, alu_op=10. Then ALUWB.
- EXECUTEI: src_a=10, src_b=01, alu_op=10. Then ALUWB.
- ALUWB: result_src=00, reg_write=1. Then FETCH.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. Then FETCH.
- JAL: result_src=00, pc_update=1, src_a=01, src_b=10, alu_op=00, so alu_out becomes old_pc+4. Then ALUWB.
- JALR1: src_a=10, src_b=01, alu_op=00. Then JALR2.
- JALR2: same outputs as JAL, so PC ← rs1+imm and alu_out ← old_pc+4. Then ALUWB.
- LUI: src_a=11, src_b=01, alu_op=00. Then ALUWB.
- AUIPC: src_a=01, src_b=01, alu_op=00. Then ALUWB.
- TRAP: all enables 0, `illegal`=1. Stays in TRAP until `rst_n` is asserted.

## Timing
- Reset:
  - While `rst_n`=0, the state is forced to FETCH immediately, without waiting for a clock edge.
  - All enables are 0 except the `mem_ready`-gated FETCH outputs.
  - `illegal`=0 and `instr_done`=0.
- Cycle counts with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal, lui, auipc: 4 cycles.
  - beq: 3 cycles.
  - jalr: 5 cycles.
  - Nop (unknown opcode with `TRAP_EN`=0): 2 cycles.
- Each extra cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is sampled on the same edge that advances the state. A `mem_ready`=1 seen in any other state has no effect.
- `instr_done` is high in the final cycle of each instruction, i.e. whenever the next state is FETCH and the current state is not FETCH.
- With `MEM_HANDSHAKE`=0, `mem_ready` is treated as constant 1.
- Reset asserted mid-instruction (including during a wait state) aborts the instruction. No write enable may stay high after `rst_n` falls.

## Test plan
- Reset, then lw (op=0000011), `mem_ready`=1: state sequence FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH. `reg_write`=1 only in cycle 5; `instr_done` pulses in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEMWRITE: `mem_write`=1 for 4 consecutive cycles; FETCH is re-entered on the cycle after `mem_ready` rises.
- beq (op=1100011) with `zero`=1 and then with `zero`=0: `pc_write`=1 in the BEQ cycle only when `zero`=1; `imm_src`=010 in both cases.
- jalr (op=1100111), `EXT_OPS`=1: `pc_write`=1 in JALR2 with src_a=01, src_b=10; ALUWB follows with result_src=00. With `EXT_OPS`=0 the same opcode drives TRAP and `illegal`=1.
- Unknown op=1111111: with `TRAP_EN`=1, `illegal` stays 1 for 20 cycles, then drops to 0 asynchronously when `rst_n` falls. With `TRAP_EN`=0, the sequence is FETCH→DECODE→FETCH with a single `instr_done` pulse.
- lui (op=0110111): in the LUI state `imm_src`=100, src_a=11, src_b=01; `reg_write` is asserted in the following cycle.
